// File: rtl/accel_output_collector.sv
// ============================================================================
// Module      : accel_output_collector
// Description : Captures one accelerator frame's output beat stream into a
//               first-word-fall-through FIFO and re-emits it on a valid/ready
//               master port. Tracks beat count, 16-bit checksum, overflow and
//               count-mismatch flags, and pulses frame_done_o once drained.
//               Optional feature macro: ACCEL_COLLECTOR_ARGMAX_EN adds
//               max_val_o / max_idx_o (unsigned running maximum and index).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_output_collector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start_i,
    input  logic [CNT_W-1:0]  expected_count_i,
    input  logic [DATA_W-1:0] acc_data_i,
    input  logic              acc_valid_i,
    input  logic              acc_done_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [CNT_W-1:0]  beat_count_o,
    output logic [15:0]       checksum_o,
    output logic              overflow_o,
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
    output logic [DATA_W-1:0] max_val_o,
    output logic [CNT_W-1:0]  max_idx_o,
`endif
    output logic              count_mismatch_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   exp_q, exp_d;
    logic [15:0]        csum_q, csum_d;
    logic               ovf_q, ovf_d;
    logic               mism_q, mism_d;
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
    logic [DATA_W-1:0]  max_val_q, max_val_d;
    logic [CNT_W-1:0]   max_idx_q, max_idx_d;
`endif

    logic               w_empty;
    logic               w_full;
    logic [PTR_W-1:0]   w_occ;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic [CNT_W-1:0]   w_count_inc;
    logic [CNT_W-1:0]   w_count_after;

    // FIFO status derived purely from the wrap-bit pointers
    always_comb begin
        w_empty = (wr_ptr_q == rd_ptr_q);
        w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        w_occ   = wr_ptr_q - rd_ptr_q;
        // Pops are legal in every state; pushes only while collecting.
        w_pop       = !w_empty && m_ready_i;
        w_push_req  = (state_q == S_COLLECT) && acc_valid_i;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        w_push      = w_push_req && (!w_full || w_pop);
        w_count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
        w_count_after = w_push ? w_count_inc : count_q;
    end

    // Next-state, pointer and frame-statistics logic
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        exp_d    = exp_q;
        csum_d   = csum_q;
        ovf_d    = ovf_q;
        mism_d   = mism_q;
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
`endif

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = w_count_inc;
            csum_d   = csum_q + 16'(acc_data_i);
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
            // Strictly greater keeps the earliest index on ties.
            if (acc_data_i > max_val_q) begin
                max_val_d = acc_data_i;
                max_idx_d = count_q;
            end
`endif
        end else if (w_push_req) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    state_d = S_COLLECT;
                    count_d = '0;
                    csum_d  = '0;
                    ovf_d   = 1'b0;
                    mism_d  = 1'b0;
                    exp_d   = expected_count_i;
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
                    max_val_d = '0;
                    max_idx_d = '0;
`endif
                end
            end
            S_COLLECT: begin
                if (acc_done_i) begin
                    state_d = S_DRAIN;
                    // Includes a beat accepted in the same cycle as acc_done.
                    if (w_count_after != exp_q) begin
                        mism_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the FIFO is empty after this edge.
                if (w_empty || ((w_occ == PTR_W'(1)) && w_pop)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer and statistics registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            exp_q    <= '0;
            csum_q   <= '0;
            ovf_q    <= 1'b0;
            mism_q   <= 1'b0;
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
            max_val_q <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
            csum_q   <= csum_d;
            ovf_q    <= ovf_d;
            mism_q   <= mism_d;
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= acc_data_i;
        end
    end

    assign m_data_o         = mem_q[rd_ptr_q[AW-1:0]];
    assign m_valid_o        = !w_empty;
    assign busy_o           = (state_q != S_IDLE);
    assign frame_done_o     = (state_q == S_DONE);
    assign beat_count_o     = count_q;
    assign checksum_o       = csum_q;
    assign overflow_o       = ovf_q;
    assign count_mismatch_o = mism_q;
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
    assign max_val_o        = max_val_q;
    assign max_idx_o        = max_idx_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_accel_output_collector.sv
// ============================================================================
// Module      : tb_accel_output_collector
// Description : Directed self-checking bench for accel_output_collector.
//               Inputs change and outputs are sampled 1 ns after posedge clk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_output_collector;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic [CNT_W-1:0]  expected_count = '0;
    logic [DATA_W-1:0] acc_data = '0;
    logic              acc_valid = 1'b0;
    logic              acc_done = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              busy;
    logic              frame_done;
    logic [CNT_W-1:0]  beat_count;
    logic [15:0]       checksum;
    logic              overflow;
    logic              count_mismatch;
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
    logic [DATA_W-1:0] max_val;
    logic [CNT_W-1:0]  max_idx;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accel_output_collector #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start_i   (frame_start),
        .expected_count_i(expected_count),
        .acc_data_i      (acc_data),
        .acc_valid_i     (acc_valid),
        .acc_done_i      (acc_done),
        .m_data_o        (m_data),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .busy_o          (busy),
        .frame_done_o    (frame_done),
        .beat_count_o    (beat_count),
        .checksum_o      (checksum),
        .overflow_o      (overflow),
`ifdef ACCEL_COLLECTOR_ARGMAX_EN
        .max_val_o       (max_val),
        .max_idx_o       (max_idx),
`endif
        .count_mismatch_o(count_mismatch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [CNT_W-1:0] exp);
        frame_start    = 1'b1;
        expected_count = exp;
        step();
        frame_start = 1'b0;
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d);
        acc_valid = 1'b1;
        acc_data  = d;
        step();
        acc_valid = 1'b0;
    endtask

    task automatic done_pulse();
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(tag, 32'(frame_done), 32'h1);
    endtask

    // Frame of four beats streamed straight through with m_ready high
    task automatic run_basic(input string pfx);
        logic [DATA_W-1:0] beats [4];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        m_ready = 1'b1;
        start_frame(16'd4);
        chk({pfx, "_busy"}, 32'(busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            push_beat(beats[i]);
            chk({pfx, "_mvalid"}, 32'(m_valid), 32'h1);
            chk({pfx, "_mdata"}, 32'(m_data), 32'(beats[i]));
        end
        done_pulse();
        chk({pfx, "_empty"}, 32'(m_valid), 32'h0);
        chk({pfx, "_cnt"}, 32'(beat_count), 32'h4);
        chk({pfx, "_csum"}, 32'(checksum), 32'h00AA);
        chk({pfx, "_fd_early"}, 32'(frame_done), 32'h0);
        wait_fd({pfx, "_fd"});
        step();
        chk({pfx, "_fd_pulse"}, 32'(frame_done), 32'h0);
        chk({pfx, "_idle"}, 32'(busy), 32'h0);
        chk({pfx, "_ovf"}, 32'(overflow), 32'h0);
        chk({pfx, "_mism"}, 32'(count_mismatch), 32'h0);
        chk({pfx, "_cnt_hold"}, 32'(beat_count), 32'h4);
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_mvalid", 32'(m_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_cnt", 32'(beat_count), 32'h0);
        chk("rst_csum", 32'(checksum), 32'h0);
        chk("rst_flags", {30'd0, overflow, count_mismatch}, 32'h0);

        // 1: basic frame
        run_basic("t1");

        // 2: overflow with consumer stalled
        m_ready = 1'b0;
        start_frame(16'(DEPTH + 2));
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_beat(8'(i + 1));
        end
        chk("t2_ovf", 32'(overflow), 32'h1);
        chk("t2_cnt", 32'(beat_count), 32'(DEPTH));
        chk("t2_csum", 32'(checksum), 32'h0088);
        done_pulse();
        chk("t2_busy", 32'(busy), 32'h1);
        chk("t2_mism", 32'(count_mismatch), 32'h1);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_fd_early", 32'(frame_done), 32'h0);
            chk("t2_mdata", 32'(m_data), 32'(i + 1));
            step();
        end
        chk("t2_fd", 32'(frame_done), 32'h1);
        chk("t2_empty", 32'(m_valid), 32'h0);
        step();

        // 3: short frame
        start_frame(16'd3);
        push_beat(8'h01);
        push_beat(8'h02);
        done_pulse();
        chk("t3_mism", 32'(count_mismatch), 32'h1);
        chk("t3_ovf", 32'(overflow), 32'h0);
        chk("t3_cnt", 32'(beat_count), 32'h2);
        wait_fd("t3_fd");
        step();

        // 4: last beat together with acc_done
        start_frame(16'd4);
        push_beat(8'h01);
        push_beat(8'h02);
        push_beat(8'h03);
        acc_valid = 1'b1;
        acc_data  = 8'h04;
        acc_done  = 1'b1;
        step();
        acc_valid = 1'b0;
        acc_done  = 1'b0;
        chk("t4_cnt", 32'(beat_count), 32'h4);
        chk("t4_csum", 32'(checksum), 32'h000A);
        chk("t4_mism", 32'(count_mismatch), 32'h0);
        wait_fd("t4_fd");
        step();

        // 5: full FIFO, push and pop together
        m_ready = 1'b0;
        start_frame(16'(DEPTH + 1));
        for (int i = 0; i < DEPTH; i++) begin
            push_beat(8'(8'h40 + i));
        end
        chk("t5_head", 32'(m_data), 32'h40);
        m_ready   = 1'b1;
        acc_valid = 1'b1;
        acc_data  = 8'h50;
        step();
        acc_valid = 1'b0;
        m_ready   = 1'b0;
        chk("t5_ovf", 32'(overflow), 32'h0);
        chk("t5_cnt", 32'(beat_count), 32'(DEPTH + 1));
        chk("t5_head2", 32'(m_data), 32'h41);
        done_pulse();
        chk("t5_mism", 32'(count_mismatch), 32'h0);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t5_mdata", 32'(m_data), (i < DEPTH - 1) ? 32'(8'h41 + i) : 32'h50);
            step();
        end
        chk("t5_fd", 32'(frame_done), 32'h1);
        step();

        // 6: reset mid-collect, then a clean frame
        m_ready = 1'b0;
        start_frame(16'd4);
        push_beat(8'h77);
        push_beat(8'h66);
        chk("t6_pre", 32'(m_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_mvalid", 32'(m_valid), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_stats", {15'd0, overflow, count_mismatch, checksum[14:0]} | 32'(beat_count), 32'h0);
        chk("t6_csum", 32'(checksum), 32'h0);
        step();
        rst = 1'b0;
        step();
        run_basic("t6b");

`ifdef ACCEL_COLLECTOR_ARGMAX_EN
        // 7: running maximum with a tie
        m_ready = 1'b1;
        start_frame(16'd4);
        chk("t7_clr", {8'd0, max_val, max_idx}, 32'h0);
        push_beat(8'd5);
        push_beat(8'd9);
        push_beat(8'd9);
        push_beat(8'd2);
        chk("t7_val", 32'(max_val), 32'd9);
        chk("t7_idx", 32'(max_idx), 32'd1);
        done_pulse();
        wait_fd("t7_fd");
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
